// File: rtl/axis_frame_pad_trunc.sv
// Frame-length conditioner: zero-pads short frames to MIN_LEN and truncates frames longer than MAX_LEN.
// One output register stage (1-cycle latency); input stalls whenever that register cannot load.
module axis_frame_pad_trunc #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int MIN_LEN    = 60,
   parameter int MAX_LEN    = 1514,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  stat_pad,
   output logic                  stat_trunc
);
   typedef enum logic [1:0] {PASS, PAD, DROP} state_t;

   localparam logic [31:0] MIN_L  = 32'(MIN_LEN);
   localparam logic [31:0] MAX_L  = 32'(MAX_LEN);
   localparam logic [31:0] KEEP_L = 32'(KEEP_WIDTH);

   state_t                state, state_nxt;
   logic [15:0]           cnt, cnt_nxt;
   logic [USER_WIDTH-1:0] pad_user, pad_user_nxt;
   logic                  load;
   logic [31:0]           n, nxt, rem_min, rem_max;

   logic                  ld_vld, ld_last, ld_pad, ld_trunc;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [KEEP_WIDTH-1:0] ld_keep;
   logic [USER_WIDTH-1:0] ld_user;

   function automatic logic [KEEP_WIDTH-1:0] lane_mask(input logic [31:0] k);
      logic [KEEP_WIDTH-1:0] m;
      for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (32'(i) < k);
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] zero_lanes(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [KEEP_WIDTH-1:0] k);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < KEEP_WIDTH; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
      return r;
   endfunction

   always_comb begin
      n = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) n = n + 32'(s_axis_tkeep[i]);
   end

   assign load    = !m_axis_tvalid || m_axis_tready;
   assign nxt     = 32'(cnt) + n;
   assign rem_min = MIN_L - 32'(cnt);
   assign rem_max = MAX_L - 32'(cnt);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pad_user_nxt  = pad_user;
      s_axis_tready = 1'b0;
      ld_vld        = 1'b0;
      ld_last       = 1'b0;
      ld_pad        = 1'b0;
      ld_trunc      = 1'b0;
      ld_data       = '0;
      ld_keep       = '0;
      ld_user       = '0;
      case (state)
         PASS: begin
            s_axis_tready = load;
            if (s_axis_tvalid && load) begin
               ld_vld  = 1'b1;
               ld_user = s_axis_tuser;
               if (nxt < MAX_L || (nxt == MAX_L && s_axis_tlast)) begin
                  ld_data = s_axis_tdata;
                  ld_keep = s_axis_tkeep;
                  cnt_nxt = nxt[15:0];
                  if (s_axis_tlast) begin
                     if (nxt >= MIN_L) begin
                        ld_last = 1'b1;
                        cnt_nxt = '0;
                     end else begin
                        // Short frame: fill the idle lanes of this beat with zeros first.
                        ld_data = zero_lanes(s_axis_tdata, s_axis_tkeep);
                        if (rem_min <= KEEP_L) begin
                           ld_keep = lane_mask(rem_min);
                           ld_last = 1'b1;
                           ld_pad  = 1'b1;
                           cnt_nxt = '0;
                        end else begin
                           ld_keep      = '1;
                           cnt_nxt      = 16'(32'(cnt) + KEEP_L);
                           pad_user_nxt = s_axis_tuser;
                           state_nxt    = PAD;
                        end
                     end
                  end
               end else begin
                  // cnt < MAX_LEN always holds here, so at least one lane survives.
                  ld_keep    = s_axis_tkeep & lane_mask(rem_max);
                  ld_data    = zero_lanes(s_axis_tdata, ld_keep);
                  ld_last    = 1'b1;
                  ld_user[0] = 1'b1;
                  ld_trunc   = 1'b1;
                  cnt_nxt    = '0;
                  if (!s_axis_tlast) state_nxt = DROP;
               end
            end
         end
         PAD: begin
            if (load) begin
               ld_vld  = 1'b1;
               ld_user = pad_user;
               if (rem_min <= KEEP_L) begin
                  ld_keep   = lane_mask(rem_min);
                  ld_last   = 1'b1;
                  ld_pad    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = PASS;
               end else begin
                  ld_keep = '1;
                  cnt_nxt = 16'(32'(cnt) + KEEP_L);
               end
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = PASS;
         end
         default: state_nxt = PASS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= PASS;
         cnt           <= '0;
         pad_user      <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
         stat_pad      <= 1'b0;
         stat_trunc    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pad_user   <= pad_user_nxt;
         stat_pad   <= ld_pad;
         stat_trunc <= ld_trunc;
         if (load) begin
            m_axis_tvalid <= ld_vld;
            m_axis_tdata  <= ld_data;
            m_axis_tkeep  <= ld_keep;
            m_axis_tlast  <= ld_last;
            m_axis_tuser  <= ld_user;
         end
      end
   end
endmodule

// File: tb/tb_axis_frame_pad_trunc.sv
// Directed bench for axis_frame_pad_trunc: table of frames with hand-computed results plus reset sequences.
`timescale 1ns/1ps
module tb_axis_frame_pad_trunc;
   localparam int MINL = 60;
   localparam int MAXL = 1514;
   localparam int BUDGET = 6000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [0:0]  s_axis_tuser = '0;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic [0:0]  m_axis_tuser;
   logic        stat_pad;
   logic        stat_trunc;

   always #5 clk = ~clk;

   axis_frame_pad_trunc #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .MIN_LEN(MINL), .MAX_LEN(MAXL), .USER_WIDTH(1)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .stat_pad(stat_pad), .stat_trunc(stat_trunc)
   );

   typedef struct {
      int         len;
      bit         usr;
      bit         bp;
      int         exp_len;
      int         exp_beats;
      logic [7:0] exp_keep;
      bit         exp_user;
      int         exp_pad;
      int         exp_trunc;
      bit         chk_tp;
   } vec_t;

   int npass = 0;
   int ntotal = 0;

   logic [7:0] got_bytes[$];
   int         got_beats, got_pad, got_trunc, stab_viol;
   int         t_in0, t_in_last, t_out0, t_out_last;
   logic [7:0] got_keep;
   logic       got_user;
   bit         timed_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
      return 8'(i * 13) ^ seed ^ 8'(i >> 8);
   endfunction

   // Drives one frame and collects the output until its tlast; stop_after>0 abandons after that many input beats.
   task automatic run_frame(input int len, input bit usr, input logic [7:0] seed, input bit bp, input int stop_after);
      int nbeats, bi, cyc;
      bit in_done, out_done, prev_stall;
      logic [63:0] pd;
      logic [7:0]  pk;
      logic        pl;
      nbeats = (len == 0) ? 1 : (len + 7) / 8;
      bi = 0; cyc = 0; in_done = 0; out_done = 0; prev_stall = 0;
      pd = '0; pk = '0; pl = 0;
      got_bytes.delete();
      got_beats = 0; got_pad = 0; got_trunc = 0; stab_viol = 0;
      t_in0 = -1; t_in_last = -1; t_out0 = -1; t_out_last = -1;
      got_keep = '0; got_user = 0; timed_out = 0;
      while (!(in_done && out_done)) begin
         if (cyc >= BUDGET) begin
            timed_out = 1;
            break;
         end
         @(negedge clk);
         m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bi < nbeats) begin
            for (int j = 0; j < 8; j++) begin
               int idx;
               idx = bi * 8 + j;
               s_axis_tkeep[j]       = (idx < len);
               s_axis_tdata[j*8 +: 8] = (idx < len) ? pat(seed, idx) : 8'hA5;
            end
            s_axis_tlast  = (bi == nbeats - 1);
            s_axis_tuser  = (bi == nbeats - 1) ? usr : 1'b0;
            s_axis_tvalid = 1'b1;
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
         end
         #1;
         if (prev_stall && (!m_axis_tvalid || m_axis_tdata != pd || m_axis_tkeep != pk || m_axis_tlast != pl))
            stab_viol++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
         if (stat_pad) got_pad++;
         if (stat_trunc) got_trunc++;
         if (m_axis_tvalid && m_axis_tready && !out_done) begin
            if (t_out0 < 0) t_out0 = cyc;
            t_out_last = cyc;
            got_beats++;
            for (int j = 0; j < 8; j++)
               if (m_axis_tkeep[j]) got_bytes.push_back(m_axis_tdata[j*8 +: 8]);
            if (m_axis_tlast) begin
               out_done = 1;
               got_keep = m_axis_tkeep;
               got_user = m_axis_tuser[0];
            end
         end
         if (s_axis_tvalid && s_axis_tready) begin
            if (t_in0 < 0) t_in0 = cyc;
            t_in_last = cyc;
            bi++;
            if (bi == nbeats) in_done = 1;
            if (stop_after > 0 && bi == stop_after) begin
               in_done = 1;
               out_done = 1;
            end
         end
         cyc++;
      end
   endtask

   task automatic check_case(input vec_t v, input logic [7:0] seed, input string tag);
      int nbad, kept;
      run_frame(v.len, v.usr, seed, v.bp, 0);
      chk({tag, " timeout"}, 64'(timed_out), 64'd0);
      chk({tag, " bytes"}, 64'(got_bytes.size()), 64'(v.exp_len));
      kept = (v.len < MAXL) ? v.len : MAXL;
      nbad = 0;
      for (int i = 0; i < got_bytes.size() && i < v.exp_len; i++)
         if (got_bytes[i] !== ((i < kept) ? pat(seed, i) : 8'h00)) nbad++;
      chk({tag, " data"}, 64'(nbad), 64'd0);
      chk({tag, " beats"}, 64'(got_beats), 64'(v.exp_beats));
      chk({tag, " last_keep"}, 64'(got_keep), 64'(v.exp_keep));
      chk({tag, " last_user"}, 64'(got_user), 64'(v.exp_user));
      chk({tag, " stat_pad"}, 64'(got_pad), 64'(v.exp_pad));
      chk({tag, " stat_trunc"}, 64'(got_trunc), 64'(v.exp_trunc));
      chk({tag, " stable"}, 64'(stab_viol), 64'd0);
      if (v.chk_tp) begin
         chk({tag, " latency"}, 64'(t_out0 - t_in0), 64'd1);
         chk({tag, " in_span"}, 64'(t_in_last - t_in0), 64'd7);
         chk({tag, " out_span"}, 64'(t_out_last - t_out0), 64'd7);
      end
   endtask

   initial begin
      vec_t tbl[14];
      vec_t f64;
      //           len  usr bp exp_len beats keep  user pad trunc tp
      tbl[0]  = '{64,   0, 0, 64,   8,   8'hFF, 0, 0, 0, 1};
      tbl[1]  = '{20,   0, 0, 60,   8,   8'h0F, 0, 1, 0, 0};
      tbl[2]  = '{1600, 0, 0, 1514, 190, 8'h03, 1, 0, 1, 0};
      tbl[3]  = '{1514, 0, 0, 1514, 190, 8'h03, 0, 0, 0, 0};
      tbl[4]  = '{64,   0, 1, 64,   8,   8'hFF, 0, 0, 0, 0};
      tbl[5]  = '{20,   0, 1, 60,   8,   8'h0F, 0, 1, 0, 0};
      tbl[6]  = '{1600, 0, 1, 1514, 190, 8'h03, 1, 0, 1, 0};
      tbl[7]  = '{0,    0, 0, 60,   8,   8'h0F, 0, 1, 0, 0};
      tbl[8]  = '{1,    1, 0, 60,   8,   8'h0F, 1, 1, 0, 0};
      tbl[9]  = '{59,   0, 0, 60,   8,   8'h0F, 0, 1, 0, 0};
      tbl[10] = '{60,   0, 0, 60,   8,   8'h0F, 0, 0, 0, 0};
      tbl[11] = '{1515, 0, 0, 1514, 190, 8'h03, 1, 0, 1, 0};
      tbl[12] = '{1520, 0, 0, 1514, 190, 8'h03, 1, 0, 1, 0};
      tbl[13] = '{1514, 1, 1, 1514, 190, 8'h03, 1, 0, 0, 0};
      f64     = '{64,   0, 0, 64,   8,   8'hFF, 0, 0, 0, 0};

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst m_tkeep", 64'(m_axis_tkeep), 64'd0);
      chk("rst m_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst m_tuser", 64'(m_axis_tuser), 64'd0);
      chk("rst stats", 64'({stat_pad, stat_trunc}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle s_tready", 64'(s_axis_tready), 64'd1);

      for (int k = 0; k < 14; k++)
         check_case(tbl[k], 8'(k * 37 + 1), $sformatf("v%0d", k));

      // Reset while zero-padding a 20-byte frame.
      run_frame(20, 0, 8'h5C, 0, 3);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      #1;
      chk("pad_mid tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("pad_mid tdata", m_axis_tdata, 64'd0);
      rst = 1'b1;
      #1;
      chk("pad_rst tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("pad_rst tkeep", 64'(m_axis_tkeep), 64'd0);
      chk("pad_rst stat", 64'({stat_pad, stat_trunc}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check_case(f64, 8'h77, "after_pad_rst");

      // Reset while discarding the tail of a 1600-byte frame.
      run_frame(1600, 0, 8'h21, 0, 195);
      chk("drop_pre trunc", 64'(got_trunc), 64'd1);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      #1;
      chk("drop_mid tready", 64'(s_axis_tready), 64'd1);
      rst = 1'b1;
      #1;
      chk("drop_rst tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("drop_rst tlast", 64'(m_axis_tlast), 64'd0);
      chk("drop_rst tuser", 64'(m_axis_tuser), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check_case(f64, 8'h3E, "after_drop_rst");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
